mb_bl_wl_programmer: RTL and testbench
======================================

// Module: mb_bl_wl_programmer
// PURPOSE
//  Memory-bank configuration sequencer sitting directly upstream of the logical tiles (io, clb).
//  Accepts one config word per handshake: a word-line address plus a bit-line data vector.
//  Drives bl[] and raises exactly one wl[] line with setup/pulse/hold timing.
//  Its bl/wl outputs connect straight to the bl/wl inputs of the tile configuration memories.
// PARAMETERS
//  NUM_BL          4  bit-line count (word width, one bit per column)
//  NUM_WL          4  word-line count (rows); address width ADDR_W = $clog2(NUM_WL), min 1
//  WL_PULSE_CYCLES 2  cycles wl is held high per write; legal range 1..15
// PORTS
//  prog_clk     in   1       programming clock; all logic on rising edge
//  prog_rst_n   in   1       asynchronous active-low reset
//  cfg_valid    in   1       config word present
//  cfg_ready    out  1       block can accept a word
//  cfg_wl_addr  in   ADDR_W  target word line
//  cfg_bl_data  in   NUM_BL  bit-line data for that row
//  bl           out  NUM_BL  bit-line drive, registered
//  wl           out  NUM_WL  word-line drive, registered, one-hot or zero
//  busy         out  1       high while any state other than IDLE
//  done         out  1       one-cycle pulse when a write completes its HOLD cycle
//  err          out  1       one-cycle pulse when a word addresses a row >= NUM_WL
// BEHAVIOUR
//  - Reset (async assert, sync release): state=IDLE; bl=0, wl=0, busy=0, done=0, err=0, cfg_ready=1.
//  - FSM IDLE -> SETUP -> PULSE -> HOLD -> IDLE:
//    - IDLE: cfg_ready=1.
//      - Handshake (cfg_valid & cfg_ready) with a legal address: latch addr/data, bl<=data, go to SETUP.
//      - Illegal address (>= NUM_WL): word is consumed; err pulses the next cycle; bl/wl untouched; stay IDLE.
//    - SETUP: 1 cycle; bl stable, wl=0.
//    - PULSE: wl[addr]=1 for exactly WL_PULSE_CYCLES cycles (down-counter); bl stable.
//    - HOLD: 1 cycle; wl=0, bl held; done pulses on the cycle after HOLD, coinciding with return to IDLE.
//    - bl keeps its last value in IDLE; it is not cleared.
//  - cfg_ready = (state==IDLE). No back-to-back overlap; throughput is 1 word per WL_PULSE_CYCLES+3 cycles.
//  - First-handshake-to-wl-rise latency is 2 cycles.
//  - wl is never multi-hot. wl and a bl change never occur in the same cycle.
//  - cfg_valid dropping mid-write has no effect. Inputs are ignored outside IDLE.
//  - Reset asserted mid-PULSE: wl drops to 0 immediately (async); the write is abandoned with no done pulse.
// CONFIGURATION
//  MB_PROG_SHADOW_EN
//  - Defined: adds ports rd_addr (in, ADDR_W) and rd_data (out, NUM_BL).
//    - A shadow register array (NUM_WL x NUM_BL, reset 0) is written at the HOLD cycle.
//    - rd_data is registered: 1-cycle read latency. An illegal rd_addr returns 0.
//  - Undefined: no shadow array; those ports are absent.
// STRUCTURE
//  - Package mb_prog_pkg holds:
//    - state enum (IDLE, SETUP, PULSE, HOLD), 2 bits;
//    - function clog2_min1;
//    - localparam PULSE_CNT_W = 4.
//  - Sub-module mb_wl_decoder (ADDR_W -> NUM_WL one-hot, with enable and out_of_range flag).
//    It is combinational; wl is registered in the parent.
// TESTING
//  1. Reset: hold prog_rst_n=0 with cfg_valid=1 -> bl=0, wl=0, busy=0, cfg_ready=1; no handshake taken.
//  2. Single write: addr=2, data=4'b1010, WL_PULSE_CYCLES=2
//     -> bl=1010 at t+1; wl=0100 at t+2..t+3; wl=0 at t+4; done at t+5; cfg_ready at t+5.
//  3. Illegal address: NUM_WL=3, addr=3 -> err pulses 1 cycle; wl stays 0; bl unchanged; no done.
//  4. Streaming: cfg_valid held high with 4 words -> exactly 4 done pulses, 7 cycles apart;
//     wl never multi-hot (assertion).
//  5. Reset mid-PULSE at the first pulse cycle -> wl=0 the same cycle; no done;
//     after release, the next write completes normally.
//  6. MB_PROG_SHADOW_EN: write rows 0..3 with 1,2,4,8, then read rd_addr=0..3
//     -> rd_data=1,2,4,8 with 1-cycle latency.

Source files
------------

// File: rtl/mb_bl_wl_programmer_pkg.sv
// ----------------------------------------------------------------------------
// mb_prog_pkg
//   Shared definitions for the memory-bank bit-line/word-line programmer:
//   - state_t      : sequencer states (IDLE, SETUP, PULSE, HOLD), 2 bits
//   - clog2_min1   : address width helper, never returns less than 1
//   - PULSE_CNT_W  : width of the word-line pulse down-counter
// ----------------------------------------------------------------------------
package mb_prog_pkg;

    localparam int PULSE_CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        PULSE = 2'd2,
        HOLD  = 2'd3
    } state_t;

    // A single-row bank still needs a 1-bit address port.
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/mb_wl_decoder.sv
// ----------------------------------------------------------------------------
// mb_wl_decoder
//   Combinational word-line address decoder.
//   Ports:
//     i_addr          in  ADDR_W  row address
//     i_en            in  1       decode enable (onehot forced to 0 when low)
//     o_onehot        out NUM_WL  one-hot row select, zero if disabled/illegal
//     o_out_of_range  out 1       address >= NUM_WL (independent of i_en)
// ----------------------------------------------------------------------------
module mb_wl_decoder #(
    parameter int NUM_WL = 4,
    parameter int ADDR_W = 2
) (
    input  logic [ADDR_W-1:0] i_addr,
    input  logic              i_en,
    output logic [NUM_WL-1:0] o_onehot,
    output logic              o_out_of_range
);

    // Extra MSB keeps the compare meaningful when NUM_WL == 2**ADDR_W.
    assign o_out_of_range = ({1'b0, i_addr} >= (ADDR_W+1)'(NUM_WL));

    always_comb begin
        o_onehot = '0;
        for (int unsigned i = 0; i < NUM_WL; i++) begin
            if (i_en && (i_addr == ADDR_W'(i))) begin
                o_onehot[i] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mb_bl_wl_programmer.sv
// ----------------------------------------------------------------------------
// mb_bl_wl_programmer
//   Memory-bank configuration sequencer. Takes one (row, data) word per
//   valid/ready handshake, drives bl[] with the data, then raises exactly one
//   wl[] line with setup / pulse / hold timing:
//     IDLE -> SETUP (1) -> PULSE (WL_PULSE_CYCLES) -> HOLD (1) -> IDLE
//   Ports:
//     prog_clk     in  1       programming clock, rising edge
//     prog_rst_n   in  1       asynchronous active-low reset
//     cfg_valid    in  1       config word present
//     cfg_ready    out 1       ready to accept a word (IDLE only)
//     cfg_wl_addr  in  ADDR_W  target row
//     cfg_bl_data  in  NUM_BL  bit-line data for the row
//     bl           out NUM_BL  registered bit-line drive, kept in IDLE
//     wl           out NUM_WL  registered word-line drive, one-hot or zero
//     busy         out 1       high outside IDLE
//     done         out 1       one-cycle pulse on return to IDLE after HOLD
//     err          out 1       one-cycle pulse after a word with row >= NUM_WL
//     rd_addr      in  ADDR_W  shadow read address   (MB_PROG_SHADOW_EN only)
//     rd_data      out NUM_BL  shadow read data, 1-cycle latency, 0 if illegal
//                                                    (MB_PROG_SHADOW_EN only)
//   Build option: define MB_PROG_SHADOW_EN to add a readable shadow copy of
//   every row written.
// ----------------------------------------------------------------------------
module mb_bl_wl_programmer
    import mb_prog_pkg::*;
#(
    parameter  int NUM_BL          = 4,
    parameter  int NUM_WL          = 4,
    parameter  int WL_PULSE_CYCLES = 2,
    localparam int ADDR_W          = clog2_min1(NUM_WL)
) (
    input  logic              prog_clk,
    input  logic              prog_rst_n,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [ADDR_W-1:0] cfg_wl_addr,
    input  logic [NUM_BL-1:0] cfg_bl_data,
    output logic [NUM_BL-1:0] bl,
    output logic [NUM_WL-1:0] wl,
    output logic              busy,
    output logic              done,
`ifdef MB_PROG_SHADOW_EN
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [NUM_BL-1:0] rd_data,
`endif
    output logic              err
);

    state_t                 r_state;
    logic [NUM_BL-1:0]      r_bl;
    logic [NUM_WL-1:0]      r_wl;
    logic [NUM_WL-1:0]      r_row;
    logic [PULSE_CNT_W-1:0] r_cnt;
    logic                   r_busy;
    logic                   r_ready;
    logic                   r_done;
    logic                   r_err;

    logic                   w_accept;
    logic [NUM_WL-1:0]      w_onehot;
    logic                   w_oor;

    assign w_accept = cfg_valid & r_ready;

    mb_wl_decoder #(
        .NUM_WL (NUM_WL),
        .ADDR_W (ADDR_W)
    ) u_wl_decoder (
        .i_addr         (cfg_wl_addr),
        .i_en           (w_accept),
        .o_onehot       (w_onehot),
        .o_out_of_range (w_oor)
    );

    always_ff @(posedge prog_clk or negedge prog_rst_n) begin
        if (!prog_rst_n) begin
            r_state <= IDLE;
            r_bl    <= '0;
            r_wl    <= '0;
            r_row   <= '0;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_ready <= 1'b1;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            unique case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        if (w_oor) begin
                            // Illegal row: word is consumed, nothing driven.
                            r_err <= 1'b1;
                        end else begin
                            r_bl    <= cfg_bl_data;
                            r_row   <= w_onehot;
                            r_state <= SETUP;
                            r_busy  <= 1'b1;
                            r_ready <= 1'b0;
                        end
                    end
                end
                SETUP: begin
                    r_wl    <= r_row;
                    r_cnt   <= PULSE_CNT_W'(WL_PULSE_CYCLES - 1);
                    r_state <= PULSE;
                end
                PULSE: begin
                    if (r_cnt == '0) begin
                        r_wl    <= '0;
                        r_state <= HOLD;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                HOLD: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                    r_ready <= 1'b1;
                    r_done  <= 1'b1;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign cfg_ready = r_ready;
    assign bl        = r_bl;
    assign wl        = r_wl;
    assign busy      = r_busy;
    assign done      = r_done;
    assign err       = r_err;

`ifdef MB_PROG_SHADOW_EN
    logic [ADDR_W-1:0] r_addr;
    logic [NUM_BL-1:0] r_shadow [NUM_WL];
    logic [NUM_BL-1:0] r_rd_data;

    always_ff @(posedge prog_clk or negedge prog_rst_n) begin
        if (!prog_rst_n) begin
            r_addr    <= '0;
            r_rd_data <= '0;
            for (int unsigned i = 0; i < NUM_WL; i++) begin
                r_shadow[i] <= '0;
            end
        end else begin
            if (w_accept && !w_oor) begin
                r_addr <= cfg_wl_addr;
            end
            if (r_state == HOLD) begin
                r_shadow[r_addr] <= r_bl;
            end
            if ({1'b0, rd_addr} < (ADDR_W+1)'(NUM_WL)) begin
                r_rd_data <= r_shadow[rd_addr];
            end else begin
                r_rd_data <= '0;
            end
        end
    end

    assign rd_data = r_rd_data;
`endif

endmodule

// File: tb/tb_mb_bl_wl_programmer.sv
// ----------------------------------------------------------------------------
// tb_mb_bl_wl_programmer
//   Directed bench. u_dut_a: 4 rows, 2-cycle pulse. u_dut_b: 3 rows,
//   4-cycle pulse (illegal-row and streaming cases).
// ----------------------------------------------------------------------------
module tb_mb_bl_wl_programmer;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // instance A
    logic       a_valid = 1'b0;
    logic [1:0] a_addr  = '0;
    logic [3:0] a_data  = '0;
    logic       a_ready, a_busy, a_done, a_err;
    logic [3:0] a_bl, a_wl;
    // instance B
    logic       b_valid = 1'b0;
    logic [1:0] b_addr  = '0;
    logic [3:0] b_data  = '0;
    logic       b_ready, b_busy, b_done, b_err;
    logic [3:0] b_bl;
    logic [2:0] b_wl;
`ifdef MB_PROG_SHADOW_EN
    logic [1:0] a_rd_addr = '0;
    logic [3:0] a_rd_data;
    logic [1:0] b_rd_addr = '0;
    logic [3:0] b_rd_data;
`endif

    mb_bl_wl_programmer #(
        .NUM_BL          (4),
        .NUM_WL          (4),
        .WL_PULSE_CYCLES (2)
    ) u_dut_a (
        .prog_clk    (clk),
        .prog_rst_n  (rst_n),
        .cfg_valid   (a_valid),
        .cfg_ready   (a_ready),
        .cfg_wl_addr (a_addr),
        .cfg_bl_data (a_data),
        .bl          (a_bl),
        .wl          (a_wl),
        .busy        (a_busy),
        .done        (a_done),
`ifdef MB_PROG_SHADOW_EN
        .rd_addr     (a_rd_addr),
        .rd_data     (a_rd_data),
`endif
        .err         (a_err)
    );

    mb_bl_wl_programmer #(
        .NUM_BL          (4),
        .NUM_WL          (3),
        .WL_PULSE_CYCLES (4)
    ) u_dut_b (
        .prog_clk    (clk),
        .prog_rst_n  (rst_n),
        .cfg_valid   (b_valid),
        .cfg_ready   (b_ready),
        .cfg_wl_addr (b_addr),
        .cfg_bl_data (b_data),
        .bl          (b_bl),
        .wl          (b_wl),
        .busy        (b_busy),
        .done        (b_done),
`ifdef MB_PROG_SHADOW_EN
        .rd_addr     (b_rd_addr),
        .rd_data     (b_rd_data),
`endif
        .err         (b_err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Full write on instance A with cycle-accurate expectations.
    task automatic a_write(input logic [1:0] addr, input logic [3:0] data,
                           input logic [3:0] exp_wl);
        check("w_pre_ready", a_ready, 1);
        a_valid = 1'b1;
        a_addr  = addr;
        a_data  = data;
        tick();
        check("w_setup_bl", a_bl, data);
        check("w_setup_wl", a_wl, 0);
        check("w_setup_ready", a_ready, 0);
        check("w_setup_busy", a_busy, 1);
        a_valid = 1'b0;
        tick();
        check("w_pulse1_wl", a_wl, exp_wl);
        check("w_pulse1_bl", a_bl, data);
        tick();
        check("w_pulse2_wl", a_wl, exp_wl);
        tick();
        check("w_hold_wl", a_wl, 0);
        check("w_hold_done", a_done, 0);
        check("w_hold_busy", a_busy, 1);
        tick();
        check("w_done", a_done, 1);
        check("w_done_ready", a_ready, 1);
        check("w_done_busy", a_busy, 0);
        check("w_done_bl", a_bl, data);
        tick();
        check("w_after_done", a_done, 0);
        check("w_idle_bl_kept", a_bl, data);
    endtask

    // Continuous invariants: wl never multi-hot; bl never changes while wl is high.
    logic [3:0] prev_a_bl, prev_b_bl;
    always @(negedge clk) begin
        if (rst_n) begin
            check("a_wl_onehot0", 32'($onehot0(a_wl)), 1);
            check("b_wl_onehot0", 32'($onehot0(b_wl)), 1);
            if (a_bl !== prev_a_bl) check("a_bl_chg_wl", a_wl, 0);
            if (b_bl !== prev_b_bl) check("b_bl_chg_wl", b_wl, 0);
        end
        prev_a_bl = a_bl;
        prev_b_bl = b_bl;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    logic [1:0] s_addr [4];
    logic [3:0] s_data [4];

    initial begin
        int idx;
        int dcount;
        int last_done;
        logic hs;

        // 1. reset with valid asserted
        a_valid = 1'b1;
        a_addr  = 2'd2;
        a_data  = 4'b1010;
        repeat (3) tick();
        check("rst_bl", a_bl, 0);
        check("rst_wl", a_wl, 0);
        check("rst_busy", a_busy, 0);
        check("rst_ready", a_ready, 1);
        check("rst_done", a_done, 0);
        check("rst_err", a_err, 0);
        check("rst_b_ready", b_ready, 1);
        rst_n   = 1'b1;
        a_valid = 1'b0;
        tick();
        check("post_rst_bl", a_bl, 0);
        check("post_rst_busy", a_busy, 0);

        // 2. single write row 2
        a_write(2'd2, 4'b1010, 4'b0100);

        // 3. illegal row on 3-row instance
        b_valid = 1'b1;
        b_addr  = 2'd3;
        b_data  = 4'b1111;
        tick();
        check("ill_err", b_err, 1);
        check("ill_wl", b_wl, 0);
        check("ill_bl", b_bl, 0);
        check("ill_busy", b_busy, 0);
        check("ill_ready", b_ready, 1);
        b_valid = 1'b0;
        tick();
        check("ill_err_drop", b_err, 0);
        check("ill_no_done", b_done, 0);
        tick();
        check("ill_no_done2", b_done, 0);

        // 4. streaming, 4 words, pulse 4 -> done every 7 cycles
        s_addr[0] = 2'd0; s_data[0] = 4'b0001;
        s_addr[1] = 2'd1; s_data[1] = 4'b0010;
        s_addr[2] = 2'd2; s_data[2] = 4'b0100;
        s_addr[3] = 2'd0; s_data[3] = 4'b1000;
        idx       = 0;
        dcount    = 0;
        last_done = -1;
        b_valid   = 1'b1;
        b_addr    = s_addr[0];
        b_data    = s_data[0];
        for (int c = 0; c < 40; c++) begin
            hs = b_valid && b_ready;
            tick();
            if (hs) begin
                check("s_bl", b_bl, s_data[idx]);
                idx++;
                if (idx < 4) begin
                    b_addr = s_addr[idx];
                    b_data = s_data[idx];
                end else begin
                    b_valid = 1'b0;
                end
            end
            if (b_done) begin
                dcount++;
                if (last_done >= 0) check("s_gap", 32'(c - last_done), 7);
                last_done = c;
            end
        end
        check("s_done_count", 32'(dcount), 4);
        check("s_words_taken", 32'(idx), 4);
        check("s_err", b_err, 0);

        // 5. reset during first pulse cycle
        a_valid = 1'b1;
        a_addr  = 2'd1;
        a_data  = 4'b0110;
        tick();
        a_valid = 1'b0;
        tick();
        check("mid_wl_before", a_wl, 4'b0010);
        #2 rst_n = 1'b0;
        #1;
        check("mid_wl_async", a_wl, 0);
        check("mid_busy_async", a_busy, 0);
        tick();
        rst_n = 1'b1;
        for (int c = 0; c < 6; c++) begin
            tick();
            check("mid_no_done", a_done, 0);
        end
        a_write(2'd3, 4'b0011, 4'b1000);

`ifdef MB_PROG_SHADOW_EN
        // 6. shadow readback
        a_write(2'd0, 4'd1, 4'b0001);
        a_write(2'd1, 4'd2, 4'b0010);
        a_write(2'd2, 4'd4, 4'b0100);
        a_write(2'd3, 4'd8, 4'b1000);
        a_rd_addr = 2'd0; tick(); check("rd0", a_rd_data, 4'd1);
        a_rd_addr = 2'd1; tick(); check("rd1", a_rd_data, 4'd2);
        a_rd_addr = 2'd2; tick(); check("rd2", a_rd_data, 4'd4);
        a_rd_addr = 2'd3; tick(); check("rd3", a_rd_data, 4'd8);
        b_rd_addr = 2'd3; tick(); check("rd_ill", b_rd_data, 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
